// File: rtl/hazard_ctrl.sv
// Hazard detection and stall/flush control for a 5-stage MIPS pipeline.
// Handles load-use and branch-operand bubbles, cache-miss freeze and stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_branch,
  input  logic             branch_taken,
  input  logic             ex_memread,
  input  logic             ex_regwrite,
  input  logic [4:0]       ex_dst_addr,
  input  logic             mem_memread,
  input  logic [4:0]       mem_dst_addr,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             pipe_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    LDBR2 = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t state_r;
  state_t state_next_s;
  logic   lu_s, bex_s, bld_s, bmem_s, miss_s, haz_s;

  // A producer register matches when it is non-zero and read by the ID instruction.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rs,
                                     input logic use_rt);
    reg_match = (a != 5'd0) && (((a == rs) && use_rs) || ((a == rt) && use_rt));
  endfunction

  // Hazard terms for the instruction currently in ID.
  always_comb begin
    lu_s   = ex_memread && reg_match(ex_dst_addr, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt);
    bex_s  = id_branch && ex_regwrite && !ex_memread &&
             reg_match(ex_dst_addr, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt);
    bld_s  = id_branch && ex_memread &&
             reg_match(ex_dst_addr, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt);
    bmem_s = id_branch && mem_memread &&
             reg_match(mem_dst_addr, id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt);
    miss_s = icache_stall || dcache_stall;
    haz_s  = ((state_r == RUN) && (lu_s || bex_s || bld_s || bmem_s)) || (state_r == LDBR2);
  end

  // Next-state logic: a cache miss freezes the FSM in either state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (!miss_s && bld_s) state_next_s = LDBR2;
        else                  state_next_s = RUN;
      end
      LDBR2: begin
        if (miss_s) state_next_s = LDBR2;
        else        state_next_s = RUN;
      end
      default: state_next_s = RUN;
    endcase
  end

  // Pipeline control outputs; priority is reset, miss, hazard, then flush.
  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_stall = 1'b0;
    pipe_en    = 1'b1;
    if (rst) begin
      pipe_en = 1'b1;
    end else if (miss_s) begin
      pipe_en = 1'b0;
    end else if (haz_s) begin
      idex_stall = 1'b1;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = id_branch && branch_taken;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= RUN;
    else     state_r <= state_next_s;
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (idex_stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      else                                      stall_cnt <= stall_cnt;
      if (ifid_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_ONE;
      else                                      flush_cnt <= flush_cnt;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (CNT_W=4): directed scenarios then random
// stimulus compared against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk;
  logic          rst;
  logic [4:0]    id_rs_addr, id_rt_addr, ex_dst_addr, mem_dst_addr;
  logic          id_uses_rs, id_uses_rt, id_branch, branch_taken;
  logic          ex_memread, ex_regwrite, mem_memread, icache_stall, dcache_stall;
  logic          pc_write, ifid_write, ifid_flush, idex_stall, pipe_en;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int vectors     = 0;
  int checks      = 0;
  int miscompares = 0;

  // Reference model: owed second bubble plus integer counters.
  bit owe_bubble = 1'b0;
  int m_scnt = 0;
  int m_fcnt = 0;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_branch(id_branch), .branch_taken(branch_taken),
    .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_dst_addr(ex_dst_addr),
    .mem_memread(mem_memread), .mem_dst_addr(mem_dst_addr),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .pipe_en(pipe_en),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit reads(input logic [4:0] a);
    return (a != 5'd0) && ((a == id_rs_addr && id_uses_rs) || (a == id_rt_addr && id_uses_rt));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (vector %0d)", tag, obs, exp_v, vectors);
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_branch = 1'b0; branch_taken = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_dst_addr = 5'd0;
    mem_memread = 1'b0; mem_dst_addr = 5'd0;
    icache_stall = 1'b0; dcache_stall = 1'b0;
  endtask

  // Apply current inputs for one clock, check outputs mid-cycle, advance the model.
  task automatic step();
    bit miss, load_use, br_alu, br_load, br_mem, bubble, e_st, e_fl, e_pc, e_pe;
    vectors++;
    @(negedge clk);
    miss     = icache_stall || dcache_stall;
    load_use = ex_memread && reads(ex_dst_addr);
    br_alu   = id_branch && ex_regwrite && !ex_memread && reads(ex_dst_addr);
    br_load  = id_branch && ex_memread && reads(ex_dst_addr);
    br_mem   = id_branch && mem_memread && reads(mem_dst_addr);
    bubble   = owe_bubble || load_use || br_alu || br_load || br_mem;
    e_pe = 1'b1; e_pc = 1'b0; e_st = 1'b0; e_fl = 1'b0;
    if (rst) begin
      e_pe = 1'b1;
    end else if (miss) begin
      e_pe = 1'b0;
    end else if (bubble) begin
      e_st = 1'b1;
    end else begin
      e_pc = 1'b1;
      e_fl = id_branch && branch_taken;
    end
    chk("pc_write",   int'(pc_write),   int'(e_pc));
    chk("ifid_write", int'(ifid_write), int'(e_pc));
    chk("ifid_flush", int'(ifid_flush), int'(e_fl));
    chk("idex_stall", int'(idex_stall), int'(e_st));
    chk("pipe_en",    int'(pipe_en),    int'(e_pe));
    chk("stall_cnt",  int'(stall_cnt),  m_scnt);
    chk("flush_cnt",  int'(flush_cnt),  m_fcnt);
    @(posedge clk);
    if (rst) begin
      owe_bubble = 1'b0; m_scnt = 0; m_fcnt = 0;
    end else if (!miss) begin
      owe_bubble = !owe_bubble && br_load;
      if (e_st && m_scnt < CMAX) m_scnt++;
      if (e_fl && m_fcnt < CMAX) m_fcnt++;
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    step(); step();
    idle();

    // lw $2 in EX, add $3,$2,$4 in ID: one bubble, then proceed.
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dst_addr = 5'd2;
    id_rs_addr = 5'd2; id_rt_addr = 5'd4; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    step();
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_dst_addr = 5'd0;
    step();

    // lw $5 in EX, beq $5,$0 in ID: two bubbles, then taken branch flushes.
    idle();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_dst_addr = 5'd5;
    id_branch = 1'b1; branch_taken = 1'b1;
    id_rs_addr = 5'd5; id_rt_addr = 5'd0; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    step();
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_dst_addr = 5'd0;
    mem_memread = 1'b1; mem_dst_addr = 5'd5;
    step();
    chk("ldbr_stall_cnt", int'(stall_cnt), 3);
    mem_memread = 1'b0; mem_dst_addr = 5'd0;
    step();
    chk("ldbr_flush_cnt", int'(flush_cnt), 1);

    // add $7 in EX, bne $7,$1 in ID: one bubble, then taken flush.
    idle();
    ex_regwrite = 1'b1; ex_dst_addr = 5'd7;
    id_branch = 1'b1; branch_taken = 1'b1;
    id_rs_addr = 5'd7; id_rt_addr = 5'd1; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    step();
    ex_regwrite = 1'b0; ex_dst_addr = 5'd0;
    step();

    // Load->branch, then a 5-cycle D-cache miss while the second bubble is owed.
    idle();
    ex_memread = 1'b1; ex_dst_addr = 5'd9;
    id_branch = 1'b1; id_rt_addr = 5'd9; id_uses_rt = 1'b1;
    step();
    ex_memread = 1'b0; ex_dst_addr = 5'd0; dcache_stall = 1'b1;
    for (int i = 0; i < 5; i++) step();
    dcache_stall = 1'b0;
    step();
    step();

    // Load into $0 read by ID: never a hazard.
    idle();
    ex_memread = 1'b1; ex_dst_addr = 5'd0; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    step();

    // Reset during the second bubble abandons it.
    idle();
    ex_memread = 1'b1; ex_dst_addr = 5'd3; id_branch = 1'b1;
    id_rs_addr = 5'd3; id_uses_rs = 1'b1;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // Random traffic over a small register pool to provoke matches.
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 59) == 0);
      id_rs_addr   = 5'($urandom_range(0, 3));
      id_rt_addr   = 5'($urandom_range(0, 3));
      id_uses_rs   = 1'($urandom);
      id_uses_rt   = 1'($urandom);
      id_branch    = ($urandom_range(0, 2) == 0);
      branch_taken = 1'($urandom);
      ex_memread   = ($urandom_range(0, 2) == 0);
      ex_regwrite  = 1'($urandom);
      ex_dst_addr  = 5'($urandom_range(0, 3));
      mem_memread  = ($urandom_range(0, 2) == 0);
      mem_dst_addr = 5'($urandom_range(0, 3));
      icache_stall = ($urandom_range(0, 11) == 0);
      dcache_stall = ($urandom_range(0, 11) == 0);
      step();
    end

    // 20 back-to-back load-use stalls saturate the 4-bit counter, then reset clears it.
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ex_memread = 1'b1; ex_dst_addr = 5'd6; id_rs_addr = 5'd6; id_uses_rs = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("stall_sat", int'(stall_cnt), CMAX);
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ex_memread = 1'b1; ex_dst_addr = 5'd6; id_rs_addr = 5'd6; id_uses_rs = 1'b1;
    step();
    chk("stall_after_rst", int'(stall_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
